// File: rtl/outerprodrc_drain.sv
// rtl/outerprodrc_drain.sv - run controller and shadow-buffered result drain for outerprodrc
module outerprodrc_drain #(
  parameter  int ROWNUM      = 2,
  parameter  int COLNUM      = 2,
  parameter  int BITWIDTH    = 4,
  parameter  int OUTBITWIDTH = 8,
  parameter  int PIPE        = 1,
  localparam int N           = ROWNUM * COLNUM,
  localparam int IDXW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  output logic                     oClr,
  output logic                     oEn,
  input  logic [N*OUTBITWIDTH-1:0] iData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [OUTBITWIDTH-1:0]   oData,
  output logic [IDXW-1:0]          oIdx,
  output logic                     oLast,
  output logic                     oBusy,
  output logic                     oDone
);

  localparam int RUNLEN = 2 ** (BITWIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, WAIT, DRAIN} state_t;

  state_t                 state;
  logic [BITWIDTH-1:0]    run_cnt;
  logic [3:0]             wait_cnt;
  logic [IDXW-1:0]        idx;
  logic [OUTBITWIDTH-1:0] shadow [N];
  logic                   done;
  logic                   last_idx;

  assign last_idx = (idx == IDXW'(N - 1));

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      run_cnt  <= '0;
      wait_cnt <= '0;
      idx      <= '0;
      done     <= 1'b0;
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (iStart) state <= CLR;
        CLR: begin
          run_cnt <= BITWIDTH'(RUNLEN - 1);
          state   <= RUN;
        end
        RUN: begin
          if (run_cnt == '0) begin
            wait_cnt <= 4'(PIPE - 1);
            state    <= WAIT;
          end else begin
            run_cnt <= run_cnt - BITWIDTH'(1);
          end
        end
        WAIT: begin
          // The array output has settled by the end of the last WAIT cycle.
          if (wait_cnt == 4'd0) begin
            for (int i = 0; i < N; i++) shadow[i] <= iData[i*OUTBITWIDTH +: OUTBITWIDTH];
            state <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DRAIN: begin
          if (iReady) begin
            if (last_idx) begin
              idx   <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oClr   = (state == CLR);
  assign oEn    = (state == RUN);
  assign oValid = (state == DRAIN);
  assign oBusy  = (state != IDLE);
  assign oLast  = (state == DRAIN) && last_idx;
  assign oDone  = done;
  assign oIdx   = idx;
  assign oData  = shadow[idx];

endmodule

// File: tb/tb_outerprodrc_drain.sv
// tb/tb_outerprodrc_drain.sv - directed self-checking bench for outerprodrc_drain
module tb_outerprodrc_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ready;
  logic [31:0] data;
  logic        clr, en, valid, last, busy, done;
  logic [7:0]  odata;
  logic [1:0]  idx;

  logic        s_start, s_ready;
  logic [47:0] s_data;
  logic        s_clr, s_en, s_valid, s_last, s_busy, s_done;
  logic [7:0]  s_odata;
  logic [2:0]  s_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  outerprodrc_drain dut (
    .iClk(clk), .iRstN(rst_n), .iStart(start), .oClr(clr), .oEn(en), .iData(data),
    .oValid(valid), .iReady(ready), .oData(odata), .oIdx(idx), .oLast(last),
    .oBusy(busy), .oDone(done)
  );

  outerprodrc_drain #(.ROWNUM(3), .COLNUM(2), .BITWIDTH(5), .OUTBITWIDTH(8), .PIPE(3)) u_sw (
    .iClk(clk), .iRstN(rst_n), .iStart(s_start), .oClr(s_clr), .oEn(s_en), .iData(s_data),
    .oValid(s_valid), .iReady(s_ready), .oData(s_odata), .oIdx(s_idx), .oLast(s_last),
    .oBusy(s_busy), .oDone(s_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the current cycle (cycle 0) and returns in the oDone cycle.
  task automatic run_and_check(input logic [31:0] d, input bit stall, input bit poke);
    logic [7:0] exp;
    start = 1'b1;
    data  = d;
    ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      checks++;
      if (clr !== (cyc == 1)) begin
        errors++; $display("FAIL clr cycle %0d: got %b want %b", cyc, clr, (cyc == 1));
      end
      checks++;
      if (en !== (cyc >= 2 && cyc <= 9)) begin
        errors++; $display("FAIL en cycle %0d: got %b want %b", cyc, en, (cyc >= 2 && cyc <= 9));
      end
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL pre_drain cycle %0d: valid=%b busy=%b done=%b want 0 1 0", cyc, valid, busy, done);
      end
      start = (poke && cyc == 5);
      tick();
    end
    start = 1'b0;
    if (stall) data = ~d;
    for (int k = 0; k < 4; k++) begin
      exp = d[k*8 +: 8];
      for (int h = 0; h < (stall ? 3 : 1); h++) begin
        ready = stall ? (h == 2) : 1'b1;
        start = (poke && k == 1 && h == 0);
        checks++;
        if (valid !== 1'b1 || idx !== k[1:0] || odata !== exp || last !== (k == 3) || done !== 1'b0) begin
          errors++;
          $display("FAIL drain k=%0d h=%0d: valid=%b idx=%0d data=%h last=%b done=%b want 1 %0d %h %b 0",
                   k, h, valid, idx, odata, last, done, k, exp, (k == 3));
        end
        tick();
      end
    end
    start = 1'b0;
    ready = 1'b1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || idx !== 2'd0) begin
      errors++; $display("FAIL done_cycle: done=%b busy=%b valid=%b idx=%0d want 1 0 0 0", done, busy, valid, idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'($urandom);
    ready = 1'($urandom);
    data  = $urandom;
    s_start = 1'b0;
    s_ready = 1'b1;
    s_data  = '0;
    #1;
    checks++;
    if ({clr, en, valid, last, busy, done} !== 6'b0 || odata !== 8'h00 || idx !== 2'd0) begin
      errors++; $display("FAIL reset_outputs: flags=%b data=%h idx=%0d want 0", {clr, en, valid, last, busy, done}, odata, idx);
    end
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL idle_busy cycle %0d: got %b want 0", i, busy);
      end
    end
  endtask

  task automatic test_single_run();
    run_and_check({8'h04, 8'hF8, 8'h02, 8'h7F}, 1'b0, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    run_and_check({8'hA5, 8'h3C, 8'h81, 8'h10}, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_ignored_start();
    run_and_check({8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL ignored_start cycle %0d: busy=%b want 0", i, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_and_check({8'h01, 8'h02, 8'h03, 8'h04}, 1'b0, 1'b0);
    run_and_check({8'hFE, 8'hDC, 8'hBA, 8'h98}, 1'b0, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_after: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mid_reset();
    data  = 32'hCAFE_F00D;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (en !== 1'b1) begin
      errors++; $display("FAIL mid_run_en: got %b want 1", en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || clr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL run_reset: en=%b clr=%b busy=%b want 0 0 0", en, clr, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 2'd2) begin
      errors++; $display("FAIL mid_drain_idx: valid=%b idx=%0d want 1 2", valid, idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || idx !== 2'd0 || odata !== 8'h00 || busy !== 1'b0 || last !== 1'b0) begin
      errors++; $display("FAIL drain_reset: valid=%b idx=%0d data=%h busy=%b last=%b want 0", valid, idx, odata, busy, last);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset cycle %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    run_and_check({8'h9A, 8'h56, 8'h34, 8'h12}, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_param_sweep();
    int  en_n, wait_n, drained;
    bit  got_done;
    en_n = 0; wait_n = 0; drained = 0; got_done = 1'b0;
    for (int k = 0; k < 6; k++) s_data[k*8 +: 8] = 8'h10 + 8'(k);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      if (s_en) en_n++;
      if (s_busy && !s_clr && !s_en && !s_valid) wait_n++;
      if (s_valid) begin
        checks++;
        if (s_idx !== 3'(drained) || s_odata !== 8'h10 + 8'(drained) || s_last !== (drained == 5)) begin
          errors++;
          $display("FAIL sweep_elem %0d: idx=%0d data=%h last=%b want %0d %h %b",
                   drained, s_idx, s_odata, s_last, drained, 8'h10 + 8'(drained), (drained == 5));
        end
        drained++;
      end
      if (s_done) got_done = 1'b1;
      tick();
    end
    checks++;
    if (en_n != 16) begin errors++; $display("FAIL sweep_en_cycles: got %0d want 16", en_n); end
    checks++;
    if (wait_n != 3) begin errors++; $display("FAIL sweep_wait_cycles: got %0d want 3", wait_n); end
    checks++;
    if (drained != 6) begin errors++; $display("FAIL sweep_drained: got %0d want 6", drained); end
    checks++;
    if (!got_done) begin errors++; $display("FAIL sweep_done: got 0 want 1 within 60 cycles"); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/outerprodrc_drain.md
# outerprodrc_drain

Run controller and result drain for the rate-coded outer-product array `outerprodrc`. On a start request it clears the array and enables it for exactly one full rate-coded period. It then snapshots the `ROWNUM*COLNUM` accumulators into a shadow buffer. Finally it streams the accumulators out one element per handshake on a valid/ready port toward the write-back stage.

## Interface
- `ROWNUM`, 2: array rows; must match `outerprodrc`.
- `COLNUM`, 2: array columns; must match `outerprodrc`.
- `BITWIDTH`, 4: sign-magnitude operand width; run length `RUNLEN = 2**(BITWIDTH-1)` cycles.
- `OUTBITWIDTH`, 8: accumulator width per element.
- `PIPE`, 1: cycles between last enabled cycle and stable `iData`; legal range 1..15.
- `iClk`, in, 1: clock, rising edge.
- `iRstN`, in, 1: asynchronous active-low reset.
- `iStart`, in, 1: start-run request; sampled only in IDLE.
- `oClr`, out, 1: drives `outerprodrc.iClr`.
- `oEn`, out, 1: drives `outerprodrc.iEn`.
- `iData`, in, `ROWNUM*COLNUM*OUTBITWIDTH`: `outerprodrc.oData`; element k = r*COLNUM+c at `[k*OUTBITWIDTH +: OUTBITWIDTH]`.
- `oValid`, out, 1: output element valid.
- `iReady`, in, 1: consumer accepts the element when `oValid && iReady`.
- `oData`, out, `OUTBITWIDTH`: current element.
- `oIdx`, out, `$clog2(ROWNUM*COLNUM)` (min 1): index k of current element.
- `oLast`, out, 1: `oValid` and `oIdx == ROWNUM*COLNUM-1`.
- `oBusy`, out, 1: state is not IDLE.
- `oDone`, out, 1: one-cycle pulse after the last element is accepted.

## Operation
- FSM states:
  - IDLE → CLR on `iStart`.
  - CLR: 1 cycle, then RUN.
  - RUN: `RUNLEN` cycles, then WAIT.
  - WAIT: `PIPE` cycles, then DRAIN.
  - DRAIN → IDLE on the last handshake.
- Outputs by state:
  - `oClr` = (state==CLR).
  - `oEn` = (state==RUN).
  - `oValid` = (state==DRAIN).
  - All are decoded from registered state; no combinational path from inputs.
- Down-counter (width `BITWIDTH`) times RUN; a separate 4-bit counter times WAIT.
- Snapshot: the full `iData` is copied into the shadow buffer on the clock edge that ends the last WAIT cycle. `iData` is ignored at all other times.
- Drain order is k = 0,1,…,N-1 with N = `ROWNUM*COLNUM`. `oData` = shadow[k]; k increments only on handshake.
- `iReady` low stalls the drain. `oValid`, `oData`, `oIdx` stay stable until accepted.
- `iStart` outside IDLE is ignored, not queued.
- The shadow buffer is not cleared between runs. Only the snapshot writes it.

## Timing
- Reset (async assert, sync release) forces:
  - state IDLE, counters 0, shadow buffer 0, k=0.
  - `oClr`=`oEn`=`oValid`=`oLast`=`oBusy`=`oDone`=0, `oData`=0, `oIdx`=0.
- Reset mid-run or mid-drain aborts immediately. There is no completion and no `oDone`.
- Run sequence, with `iStart` high in IDLE at cycle 0:
  - `oBusy`=1 and `oClr`=1 in cycle 1.
  - `oEn`=1 in cycles 2..RUNLEN+1.
  - WAIT in cycles RUNLEN+2..RUNLEN+1+PIPE.
  - First `oValid` in cycle RUNLEN+2+PIPE.
- Default parameters (RUNLEN=8, PIPE=1): `oClr` in cycle 1, `oEn` in cycles 2–9, WAIT in cycle 10, `oValid` from cycle 11.
- Each handshake cycle advances k by one. With `iReady` held high, the N elements occupy N consecutive cycles.
- After the handshake on k=N-1, the next cycle is IDLE with `oDone`=1, `oBusy`=0, `oValid`=0, k=0.
- `iStart` high during the `oDone` cycle is accepted, so back-to-back runs are possible. Total period is 1+RUNLEN+PIPE+N+1 cycles with no stalls.
- `iStart` held high continuously restarts a run each time IDLE is reached.

## Test plan
- Reset behaviour: assert `iRstN`=0 with random inputs → every output 0. Release, hold `iStart`=0 for 20 cycles → `oBusy` stays 0.
- Single run, defaults:
  - Stimulus: pulse `iStart` at cycle 0; set `iData` = {8'h04, 8'hF8, 8'h02, 8'h7F} (k3..k0) before cycle 10; hold `iReady`=1.
  - Required: `oClr` in cycle 1 only; `oEn` in exactly cycles 2–9; k0=7F, k1=02, k2=F8, k3=04 in cycles 11–14; `oLast` in cycle 14 only; `oDone` in cycle 15.
- Backpressure: same run with `iReady` toggled 0,0,1 repeatedly → each element held 3 cycles with no change. `iData` changed after the snapshot must not affect the output.
- Ignored start and back-to-back:
  - Pulse `iStart` during RUN and DRAIN → no effect.
  - Assert `iStart` in the `oDone` cycle → `oClr` in the next cycle and a second drain with the new snapshot.
- Mid-operation reset: reset during RUN, then during DRAIN with k=2 → outputs 0 immediately, no `oDone`. A subsequent normal run drains starting from k=0.
- Parameter sweep: ROWNUM=3, COLNUM=2, BITWIDTH=5, PIPE=3 → `oEn` for exactly 16 cycles, 3 WAIT cycles, 6 elements drained, `oIdx` width 3.
